// File: rtl/reg_swap_ctrl.sv
// Register bank of DEPTH x WIDTH with a three-step swap through a temp register.
// Moore FSM with registered busy/done/err/step, a load port and a combinational read port.
module reg_swap_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w,
  input  logic [AW-1:0]    addr_a,
  input  logic [AW-1:0]    addr_b,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [2:0]       step,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, T1, T2, T3, DONE, ERR} state_t;

  // One extra bit so DEPTH == 2**AW is representable in the range checks.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [AW-1:0]    a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] bank_d [DEPTH];
  logic [2:0]       step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             a_ok, b_ok, ld_ok;

  assign a_ok  = {1'b0, addr_a}  < DEPTH_W;
  assign b_ok  = {1'b0, addr_b}  < DEPTH_W;
  assign ld_ok = {1'b0, ld_addr} < DEPTH_W;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tmp_d   = tmp_q;
    bank_d  = bank_q;
    case (state_q)
      IDLE: begin
        if (w) begin
          if (!a_ok || !b_ok) begin
            state_d = ERR;
          end else begin
            a_d     = addr_a;
            b_d     = addr_b;
            state_d = (addr_a == addr_b) ? DONE : T1;
          end
        end else if (ld_en && ld_ok) begin
          bank_d[ld_addr] = ld_data;
        end
      end
      T1: begin
        tmp_d   = bank_q[a_q];
        state_d = T2;
      end
      T2: begin
        bank_d[a_q] = bank_q[b_q];
        state_d     = T3;
      end
      T3: begin
        bank_d[b_q] = tmp_q;
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies track state_q.
    step_d = {state_d == T3, state_d == T2, state_d == T1};
    busy_d = |step_d;
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tmp_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tmp_q   <= tmp_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bank_q  <= bank_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_data = bank_q[i];
      end
    end
  end

  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_reg_swap_ctrl.sv
// Scoreboard bench for reg_swap_ctrl: default, DEPTH=3 and WIDTH=16/DEPTH=8 instances.
// Expected bank contents are queued when a scenario is driven and compared via the read port.
module tb_reg_swap_ctrl;

  typedef struct {
    int          inst;
    int          scen;
    int          addr;
    logic [15:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        w0 = 0, ld0 = 0;
  logic [1:0]  aa0 = 0, ab0 = 0, lda0 = 0, rda0 = 0;
  logic [7:0]  ldd0 = 0, rdd0;
  logic [2:0]  step0;
  logic        busy0, done0, err0;

  logic        w1 = 0, ld1 = 0;
  logic [1:0]  aa1 = 0, ab1 = 0, lda1 = 0, rda1 = 0;
  logic [7:0]  ldd1 = 0, rdd1;
  logic [2:0]  step1;
  logic        busy1, done1, err1;

  logic        w2 = 0, ld2 = 0;
  logic [2:0]  aa2 = 0, ab2 = 0, lda2 = 0, rda2 = 0;
  logic [15:0] ldd2 = 0, rdd2;
  logic [2:0]  step2;
  logic        busy2, done2, err2;

  int  tests_run = 0;
  int  tests_failed = 0;
  sb_t sb [$];

  always #5 clk = ~clk;

  reg_swap_ctrl #(.WIDTH(8), .DEPTH(4), .AW(2)) dut0 (
    .clk(clk), .rst(rst), .w(w0), .addr_a(aa0), .addr_b(ab0),
    .ld_en(ld0), .ld_addr(lda0), .ld_data(ldd0), .rd_addr(rda0), .rd_data(rdd0),
    .step(step0), .busy(busy0), .done(done0), .err(err0)
  );

  reg_swap_ctrl #(.WIDTH(8), .DEPTH(3), .AW(2)) dut1 (
    .clk(clk), .rst(rst), .w(w1), .addr_a(aa1), .addr_b(ab1),
    .ld_en(ld1), .ld_addr(lda1), .ld_data(ldd1), .rd_addr(rda1), .rd_data(rdd1),
    .step(step1), .busy(busy1), .done(done1), .err(err1)
  );

  reg_swap_ctrl #(.WIDTH(16), .DEPTH(8), .AW(3)) dut2 (
    .clk(clk), .rst(rst), .w(w2), .addr_a(aa2), .addr_b(ab2),
    .ld_en(ld2), .ld_addr(lda2), .ld_data(ldd2), .rd_addr(rda2), .rd_data(rdd2),
    .step(step2), .busy(busy2), .done(done2), .err(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int inst, input int scen, input int addr, input logic [15:0] data);
    sb_t e;
    e.inst = inst;
    e.scen = scen;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic set_rd(input int inst, input int addr);
    case (inst)
      0:       rda0 = 2'(addr);
      1:       rda1 = 2'(addr);
      default: rda2 = 3'(addr);
    endcase
  endtask

  function automatic logic [15:0] rd_of(input int inst);
    case (inst)
      0:       return {8'h00, rdd0};
      1:       return {8'h00, rdd1};
      default: return rdd2;
    endcase
  endfunction

  // {step, busy, done, err} of an instance.
  function automatic logic [5:0] phase_of(input int inst);
    case (inst)
      0:       return {step0, busy0, done0, err0};
      1:       return {step1, busy1, done1, err1};
      default: return {step2, busy2, done2, err2};
    endcase
  endfunction

  // Expected handshake for cycle c after a valid request, c = 1..5 repeating.
  function automatic logic [5:0] swap_phase(input int c);
    case (c)
      1:       return 6'b001_100;
      2:       return 6'b010_100;
      3:       return 6'b100_100;
      4:       return 6'b000_010;
      default: return 6'b000_000;
    endcase
  endfunction

  task automatic load0(input int a, input logic [7:0] d);
    ld0 = 1; lda0 = 2'(a); ldd0 = d;
    tick();
    ld0 = 0;
  endtask

  task automatic load1(input int a, input logic [7:0] d);
    ld1 = 1; lda1 = 2'(a); ldd1 = d;
    tick();
    ld1 = 0;
  endtask

  task automatic load2(input int a, input logic [15:0] d);
    ld2 = 1; lda2 = 3'(a); ldd2 = d;
    tick();
    ld2 = 0;
  endtask

  task automatic test_reset();
    sb_t e;
    rst = 1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (phase_of(i) !== 6'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs dut%0d: got %b, expected 000000", i, phase_of(i));
      end
    end
    for (int i = 0; i < 4; i++) push(0, 1, i, 16'h0);
    rst = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      set_rd(e.inst, e.addr);
      #1;
      tests_run++;
      if (rd_of(e.inst) !== e.data) begin
        tests_failed++;
        $display("[TB] FAIL bank dut%0d R%0d scen%0d: got %h, expected %h", e.inst, e.addr, e.scen, rd_of(e.inst), e.data);
      end
    end
  endtask

  task automatic test_swap_basic();
    sb_t e;
    load0(0, 8'h11); load0(1, 8'h22); load0(2, 8'h33); load0(3, 8'h44);
    push(0, 2, 0, 16'h33); push(0, 2, 1, 16'h22); push(0, 2, 2, 16'h11); push(0, 2, 3, 16'h44);
    aa0 = 0; ab0 = 2; w0 = 1;
    tick();
    w0 = 0; aa0 = 1; ab0 = 1;
    for (int c = 1; c <= 4; c++) begin
      tests_run++;
      if (phase_of(0) !== swap_phase(c)) begin
        tests_failed++;
        $display("[TB] FAIL swap_phase cycle%0d: got %b, expected %b", c, phase_of(0), swap_phase(c));
      end
      if (c < 4) tick();
    end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      set_rd(e.inst, e.addr);
      #1;
      tests_run++;
      if (rd_of(e.inst) !== e.data) begin
        tests_failed++;
        $display("[TB] FAIL bank dut%0d R%0d scen%0d: got %h, expected %h", e.inst, e.addr, e.scen, rd_of(e.inst), e.data);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    sb_t e;
    aa0 = 1; ab0 = 3; w0 = 1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      tests_run++;
      if (phase_of(0) !== swap_phase((c - 1) % 5 + 1)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_phase cycle%0d: got %b, expected %b", c, phase_of(0), swap_phase((c - 1) % 5 + 1));
      end
      if (c == 5) begin
        push(0, 3, 1, 16'h44); push(0, 3, 3, 16'h22);
        while (sb.size() != 0) begin
          e = sb.pop_front();
          set_rd(e.inst, e.addr);
          #1;
          tests_run++;
          if (rd_of(e.inst) !== e.data) begin
            tests_failed++;
            $display("[TB] FAIL bank dut%0d R%0d scen%0d: got %h, expected %h", e.inst, e.addr, e.scen, rd_of(e.inst), e.data);
          end
        end
      end
    end
    w0 = 0;
    push(0, 4, 1, 16'h22); push(0, 4, 3, 16'h44);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      set_rd(e.inst, e.addr);
      #1;
      tests_run++;
      if (rd_of(e.inst) !== e.data) begin
        tests_failed++;
        $display("[TB] FAIL bank dut%0d R%0d scen%0d: got %h, expected %h", e.inst, e.addr, e.scen, rd_of(e.inst), e.data);
      end
    end
    tick();
  endtask

  task automatic test_degenerate();
    sb_t e;
    aa0 = 2; ab0 = 2; w0 = 1;
    tick();
    w0 = 0;
    tests_run++;
    if (phase_of(0) !== 6'b000_010) begin
      tests_failed++;
      $display("[TB] FAIL degenerate_done: got %b, expected 000010", phase_of(0));
    end
    tick();
    tests_run++;
    if (phase_of(0) !== 6'b000_000) begin
      tests_failed++;
      $display("[TB] FAIL degenerate_idle: got %b, expected 000000", phase_of(0));
    end
    push(0, 5, 0, 16'h33); push(0, 5, 1, 16'h22); push(0, 5, 2, 16'h11); push(0, 5, 3, 16'h44);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      set_rd(e.inst, e.addr);
      #1;
      tests_run++;
      if (rd_of(e.inst) !== e.data) begin
        tests_failed++;
        $display("[TB] FAIL bank dut%0d R%0d scen%0d: got %h, expected %h", e.inst, e.addr, e.scen, rd_of(e.inst), e.data);
      end
    end
  endtask

  task automatic test_reset_mid_swap();
    sb_t e;
    aa0 = 0; ab0 = 1; w0 = 1;
    tick();
    w0 = 0;
    tick();
    tests_run++;
    if (phase_of(0) !== 6'b010_100) begin
      tests_failed++;
      $display("[TB] FAIL midreset_in_t2: got %b, expected 010100", phase_of(0));
    end
    rst = 1;
    tick();
    rst = 0;
    tests_run++;
    if (phase_of(0) !== 6'b000_000) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got %b, expected 000000", phase_of(0));
    end
    for (int i = 0; i < 4; i++) push(0, 6, i, 16'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      set_rd(e.inst, e.addr);
      #1;
      tests_run++;
      if (rd_of(e.inst) !== e.data) begin
        tests_failed++;
        $display("[TB] FAIL bank dut%0d R%0d scen%0d: got %h, expected %h", e.inst, e.addr, e.scen, rd_of(e.inst), e.data);
      end
    end
    tick();
    tests_run++;
    if (phase_of(0) !== 6'b000_000) begin
      tests_failed++;
      $display("[TB] FAIL midreset_no_done: got %b, expected 000000", phase_of(0));
    end
  endtask

  task automatic test_load_ignore();
    sb_t e;
    load0(0, 8'h01); load0(1, 8'h02); load0(2, 8'h03); load0(3, 8'h04);
    aa0 = 0; ab0 = 2; w0 = 1;
    tick();
    w0 = 0;
    ld0 = 1; lda0 = 1; ldd0 = 8'hAA;
    tick();
    ld0 = 0;
    tick();
    tick();
    tests_run++;
    if (phase_of(0) !== 6'b000_010) begin
      tests_failed++;
      $display("[TB] FAIL load_busy_done: got %b, expected 000010", phase_of(0));
    end
    push(0, 7, 0, 16'h03); push(0, 7, 1, 16'h02); push(0, 7, 2, 16'h01); push(0, 7, 3, 16'h04);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      set_rd(e.inst, e.addr);
      #1;
      tests_run++;
      if (rd_of(e.inst) !== e.data) begin
        tests_failed++;
        $display("[TB] FAIL bank dut%0d R%0d scen%0d: got %h, expected %h", e.inst, e.addr, e.scen, rd_of(e.inst), e.data);
      end
    end
    tick();
    ld0 = 1; lda0 = 1; ldd0 = 8'hAA;
    aa0 = 0; ab0 = 2; w0 = 1;
    tick();
    ld0 = 0; w0 = 0;
    tests_run++;
    if (phase_of(0) !== 6'b001_100) begin
      tests_failed++;
      $display("[TB] FAIL w_priority_t1: got %b, expected 001100", phase_of(0));
    end
    tick(); tick(); tick();
    push(0, 8, 0, 16'h01); push(0, 8, 1, 16'h02); push(0, 8, 2, 16'h03); push(0, 8, 3, 16'h04);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      set_rd(e.inst, e.addr);
      #1;
      tests_run++;
      if (rd_of(e.inst) !== e.data) begin
        tests_failed++;
        $display("[TB] FAIL bank dut%0d R%0d scen%0d: got %h, expected %h", e.inst, e.addr, e.scen, rd_of(e.inst), e.data);
      end
    end
    tick();
  endtask

  task automatic test_reject();
    sb_t e;
    load1(0, 8'h5A); load1(1, 8'h6B); load1(2, 8'h7C); load1(3, 8'hFF);
    aa1 = 3; ab1 = 0; w1 = 1;
    tick();
    w1 = 0;
    tests_run++;
    if (phase_of(1) !== 6'b000_001) begin
      tests_failed++;
      $display("[TB] FAIL reject_err: got %b, expected 000001", phase_of(1));
    end
    tick();
    tests_run++;
    if (phase_of(1) !== 6'b000_000) begin
      tests_failed++;
      $display("[TB] FAIL reject_idle: got %b, expected 000000", phase_of(1));
    end
    push(1, 9, 0, 16'h5A); push(1, 9, 1, 16'h6B); push(1, 9, 2, 16'h7C); push(1, 9, 3, 16'h00);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      set_rd(e.inst, e.addr);
      #1;
      tests_run++;
      if (rd_of(e.inst) !== e.data) begin
        tests_failed++;
        $display("[TB] FAIL bank dut%0d R%0d scen%0d: got %h, expected %h", e.inst, e.addr, e.scen, rd_of(e.inst), e.data);
      end
    end
  endtask

  task automatic test_wide();
    sb_t e;
    load2(7, 16'hBEEF); load2(0, 16'h1234); load2(5, 16'h0000);
    aa2 = 7; ab2 = 0; w2 = 1;
    tick();
    w2 = 0;
    for (int c = 1; c <= 4; c++) begin
      tests_run++;
      if (phase_of(2) !== swap_phase(c)) begin
        tests_failed++;
        $display("[TB] FAIL wide_phase cycle%0d: got %b, expected %b", c, phase_of(2), swap_phase(c));
      end
      if (c < 4) tick();
    end
    push(2, 10, 7, 16'h1234); push(2, 10, 0, 16'hBEEF); push(2, 10, 5, 16'h0000);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      set_rd(e.inst, e.addr);
      #1;
      tests_run++;
      if (rd_of(e.inst) !== e.data) begin
        tests_failed++;
        $display("[TB] FAIL bank dut%0d R%0d scen%0d: got %h, expected %h", e.inst, e.addr, e.scen, rd_of(e.inst), e.data);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_swap_basic();
    test_back_to_back();
    test_degenerate();
    test_reset_mid_swap();
    test_load_ignore();
    test_reject();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_swap_ctrl.md
Name: reg_swap_ctrl

Overview:
- Parametrised register-swap unit: a bank of DEPTH registers, each WIDTH bits, plus one temp register.
- On a start request it exchanges the contents of two selected registers, routing the data through temp in three transfer steps.
- Provides a load port and a combinational read port so surrounding logic and benches can preset and observe the bank.
- Generalises the fixed three-register swap controller to arbitrary width, depth and addressing, with busy/done/err handshake.

Parameters:
- WIDTH, 8, data width of each register and of temp.
- DEPTH, 4, number of registers in the bank; must be >= 2.
- AW, 2, address width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- w  input  1  start request; sampled only in IDLE.
- addr_a  input  AW  first register index; latched at start.
- addr_b  input  AW  second register index; latched at start.
- ld_en  input  1  load strobe; honoured only in IDLE when w=0.
- ld_addr  input  AW  load target index.
- ld_data  input  WIDTH  load value.
- rd_addr  input  AW  read index.
- rd_data  output  WIDTH  combinational R[rd_addr]; 0 if rd_addr >= DEPTH.
- step  output  3  one-hot phase: bit0=T1 (tmp<=R[a]), bit1=T2 (R[a]<=R[b]), bit2=T3 (R[b]<=tmp); 0 otherwise.
- busy  output  1  high in T1, T2, T3.
- done  output  1  one-cycle pulse in DONE state.
- err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All bank registers and temp cleared to 0; state goes to IDLE.
  - busy=0, done=0, err=0, step=0.
  - Reset overrides everything, including an operation in progress: the swap aborts and the bank is cleared.
- States: IDLE, T1, T2, T3, DONE, ERR. All outputs are decoded from the state register (Moore).
- IDLE, w=1, both addresses < DEPTH, addr_a != addr_b:
  - Latch a=addr_a and b=addr_b.
  - Go to T1.
- IDLE, w=1, addr_a == addr_b (both valid): latch the addresses and go directly to DONE; the bank is unchanged.
- IDLE, w=1, either address >= DEPTH: go to ERR; no transfer; the bank is unchanged.
- IDLE, w=0, ld_en=1:
  - R[ld_addr] <= ld_data if ld_addr < DEPTH; otherwise the load is silently ignored.
  - State stays IDLE.
- IDLE, w=1 and ld_en=1 together: w has priority and the load is dropped.
- T1: tmp <= R[a]; go to T2.
- T2: R[a] <= R[b]; go to T3.
- T3: R[b] <= tmp; go to DONE.
- DONE: done=1; go to IDLE.
- ERR: err=1; go to IDLE.
- Handshake and latency:
  - w sampled high at edge k: busy is high for cycles k+1..k+3 and done is high in cycle k+4.
  - Swapped values are visible on rd_data from cycle k+4.
  - Degenerate request (a==b): done in cycle k+1. Rejected request: err in cycle k+1.
- Inputs outside IDLE:
  - w, ld_en and the address inputs are ignored in T1..DONE and in ERR.
  - Changing addr_a/addr_b mid-swap has no effect.
- w held high continuously: a new request is accepted on each return to IDLE, so a valid swap repeats with a 5-cycle period. The same pair swapped twice restores the original contents.
- tmp is internal and keeps its last value between operations.
- No arithmetic: pure transfers at full WIDTH.

Test Plan:
- Reset, then load R0=0x11, R1=0x22, R2=0x33, R3=0x44; pulse w with a=0, b=2 -> step=001, 010, 100 on successive cycles; done pulse at cycle k+4; afterwards R0=0x33, R2=0x11, R1=0x22, R3=0x44.
- Hold w high with a=1, b=3 for 10 cycles -> two swaps complete 5 cycles apart, done pulses at k+4 and k+9; final R1=0x22, R3=0x44 (original values restored).
- w with a=b=2 -> done at k+1, busy never high, bank unchanged. DEPTH=3 instance with a=3 -> err at k+1, no done, bank unchanged.
- Assert rst during T2 of a 0<->1 swap -> next cycle all registers read 0, busy=0, step=0, no done pulse.
- ld_en with ld_addr=1, ld_data=0xAA issued during T1 -> ignored, R1 unchanged. ld_en and w in the same IDLE cycle -> swap runs, load dropped.
- WIDTH=16, DEPTH=8, AW=3: load R7=0xBEEF, R0=0x1234; swap a=7, b=0 -> R7=0x1234, R0=0xBEEF; rd_addr=5 reads 0.
